quantize_array: RTL and testbench



---
 rtl/qgemm_quant_pkg.sv | 15 +
 rtl/quantize_elem.sv | 43 ++++
 rtl/quantize_array.sv | 102 ++++++++++
 tb/tb_quantize_array.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qgemm_quant_pkg.sv
// qgemm_quant_pkg: shared FSM encoding, clog2 and saturation helpers for the qgemm quantizer.
package qgemm_quant_pkg;
  typedef enum logic [1:0] {S_FILL = 2'd0, S_CALC = 2'd1, S_SCL = 2'd2, S_EMIT = 2'd3} state_t;
  localparam int QUANT_BIT_NUM_DEF = 8;
  localparam int QUANT_QMAX_DEF = (1 << (QUANT_BIT_NUM_DEF - 1)) - 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int qmax(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction
endpackage

// File: rtl/quantize_elem.sv
// quantize_elem: combinational FP-to-signed-int conversion of one element against a shared shift reference.
// QUANT_ROUND_EN selects round-half-away-from-zero; otherwise truncation toward zero.
module quantize_elem import qgemm_quant_pkg::*; #(
  parameter int BIT_NUM   = 8,
  parameter int FP_DATA_W = 32,
  parameter int FP_MANT_W = 23,
  parameter int FP_EXP_W  = 8
)(
  input  logic [FP_DATA_W-1:0] fp,
  input  logic [FP_EXP_W-1:0]  e_ref,
  output logic [BIT_NUM-1:0]   q
);
  localparam int MW = FP_MANT_W + 2;
  localparam logic [MW-1:0] QMAX_M = MW'(qmax(BIT_NUM));
  localparam logic [BIT_NUM-1:0] QMAX_Q = BIT_NUM'(qmax(BIT_NUM));
  logic sign;
  logic [FP_EXP_W-1:0] e;
  logic [FP_MANT_W-1:0] m;
  logic [FP_MANT_W:0] sig;
  logic in_rng;
  int sh;
  logic [MW-1:0] mag;
  logic [BIT_NUM-1:0] sat;
`ifdef QUANT_ROUND_EN
  logic [FP_MANT_W:0] rsh;
`endif
  assign sign = fp[FP_DATA_W-1];
  assign e = fp[FP_MANT_W +: FP_EXP_W];
  assign m = fp[FP_MANT_W-1:0];
  assign sig = {1'b1, m};
  always_comb begin
    sh = FP_MANT_W + int'(e_ref) - int'(e) - (BIT_NUM - 2);
    in_rng = sh >= 0 && sh < MW;
    mag = in_rng ? MW'(sig >> sh) : '0;
`ifdef QUANT_ROUND_EN
    // a shift of -1 wraps to a huge amount, so sh==0 yields no rounding bit
    rsh = sig >> (sh - 1);
    mag = mag + MW'(in_rng & rsh[0]);
`endif
    sat = mag > QMAX_M ? QMAX_Q : mag[BIT_NUM-1:0];
    q = e == '0 ? '0 : &e ? (m != '0 ? '0 : sign ? -QMAX_Q : QMAX_Q) : sign ? -sat : sat;
  end
endmodule

// File: rtl/quantize_array.sv
// quantize_array: buffers one FP tile, derives a power-of-two scale from its largest exponent,
// then emits the scale followed by the tile as signed integers (rounding via QUANT_ROUND_EN).
module quantize_array import qgemm_quant_pkg::*; #(
  parameter int BIT_NUM     = 8,
  parameter int MAT_SIZE    = 16,
  parameter int FP_DATA_W   = 32,
  parameter int FP_MANT_W   = 23,
  parameter int FP_EXP_W    = 8,
  parameter int FP_EXP_BIAS = 127,
  parameter int LANES_NUM   = 16
)(
  input  logic                           clk,
  input  logic                           rstnn,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  input  logic [LANES_NUM*FP_DATA_W-1:0] s_data_i,
  output logic                           scl_valid_o,
  input  logic                           scl_ready_i,
  output logic [FP_MANT_W-1:0]           mantissa_scale_o,
  output logic [FP_EXP_W-1:0]            exp_scale_o,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [LANES_NUM*BIT_NUM-1:0]   m_data_o
);
  localparam int ELEMS = MAT_SIZE * MAT_SIZE;
  localparam int IN_BEATS = ELEMS / LANES_NUM;
  localparam int BW = clog2(IN_BEATS) > 0 ? clog2(IN_BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(IN_BEATS - 1);
  localparam logic [FP_EXP_W-1:0] OFS = FP_EXP_W'(BIT_NUM - 2);
  if (ELEMS % LANES_NUM != 0) begin : g_bad_lanes
    $fatal(1, "quantize_array: ELEMS must be a multiple of LANES_NUM");
  end
  if (1 + FP_EXP_W + FP_MANT_W != FP_DATA_W || FP_EXP_BIAS >= (1 << FP_EXP_W)) begin : g_bad_fp
    $fatal(1, "quantize_array: inconsistent FP format parameters");
  end
  state_t state, nxt;
  logic [BW-1:0] in_beat, out_beat;
  logic [FP_EXP_W-1:0] max_exp, beat_max, e_ref;
  logic [LANES_NUM*FP_DATA_W-1:0] mem [IN_BEATS];
  logic s_fire, scl_fire, m_fire, in_last, out_last;
  assign s_fire = s_valid_i && s_ready_o;
  assign scl_fire = scl_valid_o && scl_ready_i;
  assign m_fire = m_valid_o && m_ready_i;
  assign in_last = in_beat == LAST;
  assign out_last = out_beat == LAST;
  assign mantissa_scale_o = '0;
  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn) state <= S_FILL;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      S_FILL: nxt = s_fire && in_last ? S_CALC : S_FILL;
      S_CALC: nxt = S_SCL;
      S_SCL:  nxt = scl_fire ? S_EMIT : S_SCL;
      S_EMIT: nxt = m_fire && out_last ? S_FILL : S_EMIT;
    endcase
  end
  always_comb begin
    s_ready_o = state == S_FILL;
    scl_valid_o = state == S_SCL;
    m_valid_o = state == S_EMIT;
  end
  // denormals carry exponent 0 and Inf/NaN carry all-ones, so a plain max covers all classes
  always_comb begin
    beat_max = max_exp;
    for (int i = 0; i < LANES_NUM; i++)
      beat_max = s_data_i[i*FP_DATA_W+FP_MANT_W +: FP_EXP_W] > beat_max ? s_data_i[i*FP_DATA_W+FP_MANT_W +: FP_EXP_W] : beat_max;
  end
  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn) begin
      in_beat <= '0;
      out_beat <= '0;
      max_exp <= '0;
      exp_scale_o <= '0;
      e_ref <= '0;
    end else begin
      if (s_fire) begin
        in_beat <= in_last ? '0 : in_beat + 1'b1;
        max_exp <= beat_max;
      end
      if (state == S_CALC) begin
        exp_scale_o <= max_exp > OFS ? max_exp - OFS : '0;
        e_ref <= max_exp > OFS ? max_exp : OFS;
      end
      if (m_fire) begin
        out_beat <= out_last ? '0 : out_beat + 1'b1;
        if (out_last) max_exp <= '0;
      end
    end
  always_ff @(posedge clk)
    if (s_fire) mem[in_beat] <= s_data_i;
  for (genvar g = 0; g < LANES_NUM; g++) begin : g_lane
    quantize_elem #(
      .BIT_NUM(BIT_NUM), .FP_DATA_W(FP_DATA_W), .FP_MANT_W(FP_MANT_W), .FP_EXP_W(FP_EXP_W)
    ) u_q (
      .fp(mem[out_beat][g*FP_DATA_W +: FP_DATA_W]),
      .e_ref(e_ref),
      .q(m_data_o[g*BIT_NUM +: BIT_NUM])
    );
  end
endmodule

// File: tb/tb_quantize_array.sv
// tb_quantize_array: scoreboard bench for quantize_array; expectations come from a real-valued model.
module tb_quantize_array;
  localparam int L = 16;
  localparam int BN = 8;
  localparam int IB = 16;
  localparam int N = 256;
  logic clk = 1'b0;
  logic rstnn;
  logic s_valid, s_ready, scl_valid, scl_ready, m_valid, m_ready;
  logic [L*32-1:0] s_data;
  logic [22:0] mant_scale;
  logic [7:0] exp_scale;
  logic [L*BN-1:0] m_data;
  int checks = 0;
  int failures = 0;
  logic [31:0] tile [N];
  logic [L*BN-1:0] rx [IB];
  logic [7:0] got_scale;
  logic [L*BN-1:0] exp_q [$];
  logic [7:0] exp_scl [$];

  quantize_array dut (
    .clk(clk), .rstnn(rstnn),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .scl_valid_o(scl_valid), .scl_ready_i(scl_ready),
    .mantissa_scale_o(mant_scale), .exp_scale_o(exp_scale),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_q(input logic [31:0] x, input int es);
    int e, m;
    real v;
    e = int'(x[30:23]);
    if (e == 0) return 8'h00;
    if (e == 255) return (x[22:0] != 0) ? 8'h00 : (x[31] ? 8'h81 : 8'h7F);
    v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** real'(e - es));
`ifdef QUANT_ROUND_EN
    v = v + 0.5;
`endif
    m = (v >= 127.0) ? 127 : $rtoi(v);
    return x[31] ? 8'(-m) : 8'(m);
  endfunction

  function automatic int model_scale();
    int mx;
    mx = 0;
    for (int i = 0; i < N; i++) if (int'(tile[i][30:23]) > mx) mx = int'(tile[i][30:23]);
    return mx > 6 ? mx - 6 : 0;
  endfunction

  function automatic logic [7:0] rx_q(input int i);
    return rx[i/L][(i%L)*BN +: BN];
  endfunction

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < N; i++) tile[i] = v;
  endtask

  task automatic push_tile();
    int es;
    logic [L*BN-1:0] eb;
    es = model_scale();
    exp_scl.push_back(8'(es));
    for (int b = 0; b < IB; b++) begin
      for (int l = 0; l < L; l++) eb[l*BN +: BN] = model_q(tile[b*L+l], es);
      exp_q.push_back(eb);
    end
  endtask

  task automatic drive_beats(input int n);
    int tries;
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      s_valid = 1'b1;
      for (int l = 0; l < L; l++) s_data[l*32 +: 32] = tile[b*L+l];
      tries = 0;
      while (!s_ready && tries < 50) begin
        @(negedge clk);
        tries++;
      end
      checks++;
      if (tries == 50) begin
        failures++;
        $display("FAIL fill_timeout beat=%0d s_ready=%b required=1", b, s_ready);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic collect(input int scl_hold, input bit toggle, input bit s_busy, input int nbeats, input bit chk_lat);
    int cyc, beats, scl_cnt, first_mv;
    bit tg, pmv, pmr, psv, psr;
    logic [L*BN-1:0] pdata, eb;
    logic [7:0] pexp, es;
    cyc = 1; beats = 0; scl_cnt = 0; first_mv = 0;
    tg = 0; pmv = 0; pmr = 0; psv = 0; psr = 0;
    pdata = '0; pexp = '0;
    if (s_busy) begin
      s_valid = 1'b1;
      s_data = {L{32'h3F800000}};
    end
    while (beats < nbeats && cyc < 400) begin
      checks++;
      if (s_ready !== 1'b0) begin
        failures++;
        $display("FAIL s_ready_busy cyc=%0d got=%b required=0", cyc, s_ready);
      end
      if (psv && !psr) begin
        checks++;
        if (scl_valid !== 1'b1 || exp_scale !== pexp) begin
          failures++;
          $display("FAIL scl_hold valid=%b exp=%0d required valid=1 exp=%0d", scl_valid, exp_scale, pexp);
        end
      end
      if (pmv && !pmr) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== pdata) begin
          failures++;
          $display("FAIL m_hold valid=%b data=%h required valid=1 data=%h", m_valid, m_data, pdata);
        end
      end
      scl_ready = scl_cnt >= scl_hold;
      if (scl_valid) scl_cnt++;
      if (scl_valid && scl_ready) begin
        es = exp_scl.size() > 0 ? exp_scl.pop_front() : 8'hXX;
        got_scale = exp_scale;
        checks++;
        if (exp_scale !== es || mant_scale !== 23'd0) begin
          failures++;
          $display("FAIL scale exp=%0d mant=%h required exp=%0d mant=0", exp_scale, mant_scale, es);
        end
      end
      m_ready = toggle ? tg : 1'b1;
      tg = ~tg;
      if (m_valid && first_mv == 0) first_mv = cyc;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat beat=%0d data=%h required none", beats, m_data);
        end else begin
          eb = exp_q.pop_front();
          if (m_data !== eb) begin
            failures++;
            $display("FAIL beat%0d got=%h required=%h", beats, m_data, eb);
          end
        end
        rx[beats] = m_data;
        beats++;
      end
      psv = scl_valid; psr = scl_ready; pexp = exp_scale;
      pmv = m_valid; pmr = m_ready; pdata = m_data;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (beats < nbeats) begin
      failures++;
      $display("FAIL emit_timeout beats=%0d required=%0d", beats, nbeats);
    end
    if (chk_lat) begin
      checks++;
      if (first_mv != 3) begin
        failures++;
        $display("FAIL latency first_m_valid_cycle=%0d required=3", first_mv);
      end
    end
    if (nbeats == IB) begin
      checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL tile_end s_ready=%b m_valid=%b left=%0d required 1 0 0", s_ready, m_valid, exp_q.size());
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    scl_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (s_ready !== 1'b1 || scl_valid !== 1'b0 || m_valid !== 1'b0 || exp_scale !== 8'd0 || mant_scale !== 23'd0) begin
      failures++;
      $display("FAIL %s s_ready=%b scl_valid=%b m_valid=%b exp=%0d mant=%h required 1 0 0 0 0",
               tag, s_ready, scl_valid, m_valid, exp_scale, mant_scale);
    end
  endtask

  task automatic check_q(input string tag, input int idx, input logic [7:0] want);
    checks++;
    if (rx_q(idx) !== want) begin
      failures++;
      $display("FAIL %s idx=%0d got=%0d required=%0d", tag, idx, $signed(rx_q(idx)), $signed(want));
    end
  endtask

  task automatic check_scale(input string tag, input logic [7:0] want);
    checks++;
    if (got_scale !== want) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", tag, got_scale, want);
    end
  endtask

  task automatic test_reset();
    #1 check_idle("reset_held");
    repeat (2) @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);
    check_idle("reset_released");
  endtask

  task automatic test_basic();
    set_all(32'h3F800000);
    tile[37] = 32'h40400000;
    push_tile();
    drive_beats(IB);
    collect(0, 0, 0, IB, 1);
    check_scale("basic_scale", 8'd122);
    check_q("basic_q3", 37, 8'd96);
    check_q("basic_q1_first", 0, 8'd32);
    check_q("basic_q1_neighbour", 36, 8'd32);
  endtask

  task automatic test_round();
    set_all(32'h3F800000);
    tile[5] = 32'h407F5C29;
    tile[100] = 32'hC0200000;
    tile[255] = 32'h3C23D70A;
    push_tile();
    drive_beats(IB);
    collect(0, 0, 0, IB, 0);
    check_scale("round_scale", 8'd122);
    check_q("q_3p99", 5, 8'd127);
    check_q("q_m2p5", 100, 8'hB0);
    check_q("q_0p01", 255, 8'd0);
  endtask

  task automatic test_zero();
    logic [L*BN-1:0] acc;
    set_all(32'h00000000);
    tile[3] = 32'h00000001;
    tile[9] = 32'h80000000;
    tile[200] = 32'h807FFFFF;
    push_tile();
    drive_beats(IB);
    collect(0, 0, 0, IB, 0);
    check_scale("zero_scale", 8'd0);
    acc = '0;
    for (int b = 0; b < IB; b++) acc = acc | rx[b];
    checks++;
    if (acc !== '0) begin
      failures++;
      $display("FAIL zero_tile_or got=%h required=0", acc);
    end
  endtask

  task automatic test_special();
    set_all(32'h3F800000);
    tile[0] = 32'h7F800000;
    tile[17] = 32'hFF800000;
    tile[250] = 32'h7FC00000;
    push_tile();
    drive_beats(IB);
    collect(0, 0, 0, IB, 0);
    check_scale("special_scale", 8'd249);
    check_q("q_pinf", 0, 8'd127);
    check_q("q_ninf", 17, 8'h81);
    check_q("q_nan", 250, 8'd0);
    check_q("q_finite_vs_inf", 1, 8'd0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++)
      tile[i] = {1'($urandom), 8'(120 + $urandom_range(0, 10)), 23'($urandom)};
    push_tile();
    drive_beats(IB);
    collect(5, 1, 1, IB, 0);
  endtask

  task automatic test_reset_fill();
    set_all(32'h447A0000);
    drive_beats(3);
    rstnn = 1'b0;
    #1 check_idle("reset_mid_fill");
    @(negedge clk);
    rstnn = 1'b1;
    set_all(32'h3F800000);
    tile[200] = 32'h40400000;
    push_tile();
    drive_beats(IB);
    collect(0, 0, 0, IB, 1);
    check_scale("after_fill_reset_scale", 8'd122);
    check_q("after_fill_reset_q3", 200, 8'd96);
  endtask

  task automatic test_reset_emit();
    set_all(32'hC0200000);
    tile[7] = 32'h447A0000;
    push_tile();
    drive_beats(IB);
    collect(0, 0, 0, 5, 0);
    rstnn = 1'b0;
    #1 check_idle("reset_mid_emit");
    exp_q.delete();
    exp_scl.delete();
    @(negedge clk);
    rstnn = 1'b1;
    set_all(32'h3F800000);
    tile[3] = 32'h40400000;
    push_tile();
    drive_beats(IB);
    collect(0, 0, 0, IB, 1);
    check_scale("after_emit_reset_scale", 8'd122);
    check_q("after_emit_reset_q3", 3, 8'd96);
  endtask

  initial begin
    rstnn = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    scl_ready = 1'b0;
    m_ready = 1'b0;
    got_scale = '0;
    test_reset();
    test_basic();
    test_round();
    test_zero();
    test_special();
    test_backpressure();
    test_reset_fill();
    test_reset_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
